// File: rtl/riscv_pkg.sv
// Shared fetch-path types: widths, the fetch entry handed to decode, and fetch FSM states.
package riscv_pkg;
    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [ADDR_W-1:0]  pc_plus4;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO with flush; when empty the head keeps showing the last popped entry.
module fetch_skid_fifo #(
    parameter int W = 160
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [1:0]   count,
    output logic [W-1:0] head
);
    logic [W-1:0] mem [2];
    logic [W-1:0] last;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         wr_en;
    logic         rd_en;

    assign rd_en = pop && (count != 2'd0);
    // A full FIFO only accepts a write when the head leaves in the same cycle.
    assign wr_en = push && ((count != 2'd2) || rd_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            last   <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (rd_en) begin
                last   <= mem[rd_ptr];
                rd_ptr <= ~rd_ptr;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = (count != 2'd0) ? mem[rd_ptr] : last;
endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: PC register, next-PC select with redirect/fault handling, skid FIFO to decode.
module fetch_pc_unit #(
    parameter int                ADDR_W   = riscv_pkg::ADDR_W,
    parameter int                INSTR_W  = riscv_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [ADDR_W-1:0]  out_pc_plus4,
    output logic [INSTR_W-1:0] out_instr,
    output logic               fault
);
    import riscv_pkg::*;

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n, pc_inc;
    logic [1:0]        count;
    logic              deq, push, flush, pop;
    fetch_entry_t      push_entry, head_entry;

    assign pc_inc    = pc + ADDR_W'(PC_INC);
    assign imem_addr = pc;
    assign out_valid = (count != 2'd0);
    assign deq       = out_valid && out_ready;
    assign fault     = (state == FAULT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            pc    <= RESET_PC;
        end else begin
            state <= state_n;
            pc    <= pc_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        push    = 1'b0;
        flush   = 1'b0;
        case (state)
            RUN: begin
                if (redirect) begin
                    // Any redirect drops wrong-path entries; a misaligned target also halts fetch.
                    flush = 1'b1;
                    if (redirect_target[1:0] == 2'b00) pc_n = redirect_target;
                    else                               state_n = FAULT;
                end else if ((count != 2'd2) || deq) begin
                    push = 1'b1;
                    pc_n = pc_inc;
                end
            end
            FAULT: begin
                state_n = FAULT;
            end
            default: state_n = RUN;
        endcase
    end

    assign pop = deq && !flush;

    assign push_entry.pc       = pc;
    assign push_entry.pc_plus4 = pc_inc;
    assign push_entry.instr    = imem_rdata;

    fetch_skid_fifo #(
        .W($bits(fetch_entry_t))
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (push_entry),
        .count (count),
        .head  (head_entry)
    );

    assign out_pc       = head_entry.pc;
    assign out_pc_plus4 = head_entry.pc_plus4;
    assign out_instr    = head_entry.instr;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: queue-based fetch model checked every cycle, directed scenarios, random traffic.
module tb_fetch_pc_unit;
    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect = 1'b0;
    logic [63:0] redirect_target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_pc, out_pc_plus4;
    logic [31:0] out_instr;
    logic        fault;
    logic        imem_mode = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;

    fetch_pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_pc          (out_pc),
        .out_pc_plus4    (out_pc_plus4),
        .out_instr       (out_instr),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_val(input logic mode, input logic [63:0] a);
        return mode ? (a[33:2] ^ 32'h9E37_79B9) : 32'h0000_0013;
    endfunction

    always_comb imem_rdata = imem_val(imem_mode, imem_addr);

    // Reference model: architectural PC, ordered queue of fetched entries, sticky fault.
    logic [63:0]  m_pc;
    logic         m_fault;
    logic         m_ok = 1'b0;
    fetch_entry_t m_q[$];
    fetch_entry_t m_last;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic compare_all();
        fetch_entry_t h;
        h = (m_q.size() != 0) ? m_q[0] : m_last;
        check("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        check("imem_addr", imem_addr, m_pc);
        check("fault", 64'(fault), 64'(m_fault));
        check("out_pc", out_pc, h.pc);
        check("out_pc_plus4", out_pc_plus4, h.pc_plus4);
        check("out_instr", 64'(out_instr), 64'(h.instr));
    endtask

    task automatic model_step();
        fetch_entry_t e;
        if (reset) begin
            m_ok    = 1'b1;
            m_pc    = '0;
            m_fault = 1'b0;
            m_q.delete();
            m_last  = '0;
        end else if (m_ok && !m_fault) begin
            if (redirect) begin
                m_q.delete();
                if (redirect_target % 4 == 0) m_pc = redirect_target;
                else                          m_fault = 1'b1;
            end else begin
                if (m_q.size() != 0 && out_ready) m_last = m_q.pop_front();
                if (m_q.size() < 2) begin
                    e.pc       = m_pc;
                    e.pc_plus4 = m_pc + 64'd4;
                    e.instr    = imem_val(imem_mode, m_pc);
                    m_q.push_back(e);
                    m_pc = m_pc + 64'd4;
                end
            end
        end
    endtask

    task automatic tick();
        #3;
        if (m_ok) compare_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;

        // Reset state and straight-line fetch of NOPs
        imem_mode = 1'b0; out_ready = 1'b1;
        do_reset();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_addr", imem_addr, 64'd0);
        check("rst_fault", 64'(fault), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("seq_pc", out_pc, 64'(4 * k));
            check("seq_pc4", out_pc_plus4, 64'(4 * k + 4));
            check("seq_instr", 64'(out_instr), 64'h13);
        end

        // Backpressure from reset: stall at two entries, then drain in order
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 5; k++) tick();
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_addr", imem_addr, 64'd8);
        check("stall_head", out_pc, 64'd0);
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            tick();
            check("drain_pc", out_pc, 64'(4 * k));
        end

        // Redirect with full FIFO
        out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 3; k++) tick();
        redirect = 1'b1; redirect_target = 64'd2048;
        tick();
        redirect = 1'b0;
        check("redir_valid", 64'(out_valid), 64'd0);
        check("redir_addr", imem_addr, 64'd2048);
        out_ready = 1'b1;
        tick();
        check("redir_pc0", out_pc, 64'd2048);
        tick();
        check("redir_pc1", out_pc, 64'd2052);

        // Misaligned redirect faults; later redirects ignored until reset
        redirect = 1'b1; redirect_target = 64'd4098;
        tick();
        redirect = 1'b0;
        check("flt_fault", 64'(fault), 64'd1);
        check("flt_valid", 64'(out_valid), 64'd0);
        check("flt_addr", imem_addr, 64'd2056);
        redirect = 1'b1; redirect_target = 64'd4096;
        tick();
        redirect = 1'b0;
        tick();
        check("flt_hold_addr", imem_addr, 64'd2056);
        check("flt_hold_fault", 64'(fault), 64'd1);
        do_reset();
        check("flt_rst_fault", 64'(fault), 64'd0);
        check("flt_rst_addr", imem_addr, 64'd0);

        // PC wraps at the top of the address space
        redirect = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        check("wrap_pc4", out_pc_plus4, 64'd0);
        tick();
        check("wrap_next", out_pc, 64'd0);
        check("wrap_fault", 64'(fault), 64'd0);

        // Reset beats a simultaneous redirect with FIFO full
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        reset = 1'b1; redirect = 1'b1; redirect_target = 64'd512;
        tick();
        reset = 1'b0; redirect = 1'b0;
        check("rstredir_valid", 64'(out_valid), 64'd0);
        check("rstredir_addr", imem_addr, 64'd0);
        check("rstredir_fault", 64'(fault), 64'd0);

        // Random traffic against the model
        imem_mode = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 59) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            redirect  = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0:       redirect_target = {$urandom, $urandom};
                1:       redirect_target = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 3) * 4);
                default: redirect_target = {$urandom, $urandom} & ~64'd3;
            endcase
            tick();
        end
        reset = 1'b0; redirect = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
